// File: rtl/gemm_array_accelerator_pkg.sv
// -----------------------------------------------------------------------------
// gemm_array_pkg
// Shared definitions for the output-stationary GEMM array:
//   - default width / array-shape constants
//   - FSM state encoding
//   - helper that sign/zero-extends two operands and multiplies them
//   - helper that returns the index of the last tile along one dimension
// -----------------------------------------------------------------------------
package gemm_array_pkg;

    localparam int unsigned DefInDataWidth   = 8;
    localparam int unsigned DefOutDataWidth  = 32;
    localparam int unsigned DefAddrWidth     = 12;
    localparam int unsigned DefSizeAddrWidth = 8;
    localparam int unsigned DefNumRows       = 2;
    localparam int unsigned DefNumCols       = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Extends two width-bit operands (width <= 32) to 64 bits according to
    // is_signed and multiplies them. The low 64 bits of the product of the
    // extended operands equal the correctly extended 2*width-bit product, so a
    // caller may truncate the result to any accumulator width up to 64.
    function automatic logic [63:0] extended_product(
        input logic [31:0]  a,
        input logic [31:0]  b,
        input logic         is_signed,
        input int unsigned  width
    );
        logic [63:0] mask;
        logic [63:0] a_ext;
        logic [63:0] b_ext;
        mask  = (64'd1 << width) - 64'd1;
        a_ext = {32'd0, a} & mask;
        b_ext = {32'd0, b} & mask;
        if (is_signed && (((a_ext >> (width - 1)) & 64'd1) != 64'd0)) begin
            a_ext = a_ext | ~mask;
        end
        if (is_signed && (((b_ext >> (width - 1)) & 64'd1) != 64'd0)) begin
            b_ext = b_ext | ~mask;
        end
        return a_ext * b_ext;
    endfunction

    // Index of the last tile when a dimension of `size` elements is covered by
    // `lanes` parallel lanes, i.e. ceil(size/lanes) - 1. Only meaningful for
    // size > 0; zero sizes never reach the tile loop.
    function automatic int unsigned last_tile_index(
        input int unsigned size,
        input int unsigned lanes
    );
        return (size + lanes - 1) / lanes - 1;
    endfunction

endpackage

// File: rtl/gemm_array_accelerator_if.sv
// -----------------------------------------------------------------------------
// gemm_array_accelerator_if
// Control and scratchpad bus of the GEMM array.
//   control : start_i, signed_i, M/K/N_size_i in; busy_o, done_o out
//   SRAM A  : one address out / read data in per array row
//   SRAM B  : one address out / read data in per array column
//   SRAM C  : one write port per MAC lane (lane index r*NumCols+c)
// Signal suffixes are seen from the accelerator. Modport master is the
// accelerator, modport slave is the host plus memories.
// Instance parameters must match those of the accelerator it connects to.
// -----------------------------------------------------------------------------
interface gemm_array_accelerator_if
    import gemm_array_pkg::*;
#(
    parameter int unsigned InDataWidth   = DefInDataWidth,
    parameter int unsigned OutDataWidth  = DefOutDataWidth,
    parameter int unsigned AddrWidth     = DefAddrWidth,
    parameter int unsigned SizeAddrWidth = DefSizeAddrWidth,
    parameter int unsigned NumRows       = DefNumRows,
    parameter int unsigned NumCols       = DefNumCols
);

    logic                                                start_i;
    logic                                                signed_i;
    logic [SizeAddrWidth-1:0]                            M_size_i;
    logic [SizeAddrWidth-1:0]                            K_size_i;
    logic [SizeAddrWidth-1:0]                            N_size_i;

    logic [NumRows-1:0][AddrWidth-1:0]                   sram_a_addr_o;
    logic [NumCols-1:0][AddrWidth-1:0]                   sram_b_addr_o;
    logic [NumRows-1:0][InDataWidth-1:0]                 sram_a_rdata_i;
    logic [NumCols-1:0][InDataWidth-1:0]                 sram_b_rdata_i;

    logic [NumRows*NumCols-1:0][AddrWidth-1:0]           sram_c_addr_o;
    logic [NumRows*NumCols-1:0][OutDataWidth-1:0]        sram_c_wdata_o;
    logic [NumRows*NumCols-1:0]                          sram_c_we_o;

    logic                                                busy_o;
    logic                                                done_o;

    modport master (
        input  start_i, signed_i, M_size_i, K_size_i, N_size_i,
        input  sram_a_rdata_i, sram_b_rdata_i,
        output sram_a_addr_o, sram_b_addr_o,
        output sram_c_addr_o, sram_c_wdata_o, sram_c_we_o,
        output busy_o, done_o
    );

    modport slave (
        output start_i, signed_i, M_size_i, K_size_i, N_size_i,
        output sram_a_rdata_i, sram_b_rdata_i,
        input  sram_a_addr_o, sram_b_addr_o,
        input  sram_c_addr_o, sram_c_wdata_o, sram_c_we_o,
        input  busy_o, done_o
    );

endinterface

// File: rtl/gemm_array_accelerator_mac_pe.sv
// -----------------------------------------------------------------------------
// gemm_mac_pe
// One MAC lane of the output-stationary array.
//   clk_i, rst_i : clock, synchronous active-high reset
//   a, b         : operands (InDataWidth)
//   is_signed    : 1 = two's complement operands, 0 = unsigned
//   valid        : operands on a/b are live this cycle
//   first        : first term of a dot product; load instead of accumulate
//   acc          : registered accumulator (OutDataWidth, wraps)
// -----------------------------------------------------------------------------
module gemm_mac_pe
    import gemm_array_pkg::*;
#(
    parameter int unsigned InDataWidth  = DefInDataWidth,
    parameter int unsigned OutDataWidth = DefOutDataWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [InDataWidth-1:0]  a,
    input  logic [InDataWidth-1:0]  b,
    input  logic                    is_signed,
    input  logic                    valid,
    input  logic                    first,
    output logic [OutDataWidth-1:0] acc
);

    logic [OutDataWidth-1:0] product;

    always_comb begin
        product = OutDataWidth'(extended_product(32'(a), 32'(b), is_signed, InDataWidth));
    end

    // NOTE: the accumulator is a plain register, not a memory array, so it is
    // cheap to clear on reset; that keeps wdata at 0 out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc <= '0;
        end else if (valid) begin
            acc <= first ? product : acc + product;
        end
    end

endmodule

// File: rtl/gemm_array_accelerator.sv
// -----------------------------------------------------------------------------
// gemm_array_accelerator
// Output-stationary GEMM engine, C = A*B, over a NumRows x NumCols MAC array.
// Each output tile of NumRows x NumCols elements is computed in K fetch cycles,
// one drain cycle and one write cycle. Tiles are walked with the column-tile
// index innermost.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : control handshake and A/B/C scratchpad ports (master side)
// All bus outputs are decoded from registered state, so they are 0 in IDLE and
// therefore in the cycle after any reset.
// -----------------------------------------------------------------------------
module gemm_array_accelerator
    import gemm_array_pkg::*;
#(
    parameter int unsigned InDataWidth   = DefInDataWidth,
    parameter int unsigned OutDataWidth  = DefOutDataWidth,
    parameter int unsigned AddrWidth     = DefAddrWidth,
    parameter int unsigned SizeAddrWidth = DefSizeAddrWidth,
    parameter int unsigned NumRows       = DefNumRows,
    parameter int unsigned NumCols       = DefNumCols
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    gemm_array_accelerator_if.master  bus
);

    localparam int unsigned NumLanes = NumRows * NumCols;

    state_e state_q, state_d;

    // Job parameters latched at start; the inputs may change afterwards.
    logic [SizeAddrWidth-1:0] m_size_q, k_size_q, n_size_q;
    logic [SizeAddrWidth-1:0] tm_last_q, tn_last_q;
    logic                     signed_q;

    // Loop counters: k within a tile, (tm, tn) tile coordinates.
    logic [SizeAddrWidth-1:0] k_q, tm_q, tn_q;

    // Fetch k is issued in one cycle and its data arrives in the next, so the
    // MAC enables are the FETCH indication delayed by one cycle.
    logic valid_q, first_q;

    logic start_accept, zero_size, fetch_last, last_tile;

    logic [AddrWidth-1:0] m_idx [NumRows];
    logic [AddrWidth-1:0] n_idx [NumCols];
    logic [NumRows-1:0]   row_ok;
    logic [NumCols-1:0]   col_ok;

    logic [OutDataWidth-1:0] acc [NumLanes];

    logic [NumRows-1:0][AddrWidth-1:0]     a_addr;
    logic [NumCols-1:0][AddrWidth-1:0]     b_addr;
    logic [NumLanes-1:0][AddrWidth-1:0]    c_addr;
    logic [NumLanes-1:0][OutDataWidth-1:0] c_wdata;
    logic [NumLanes-1:0]                   c_we;

    // ------------------------------------------------------------------ FSM
    assign start_accept = (state_q == ST_IDLE) && bus.start_i;
    assign zero_size    = (bus.M_size_i == '0) || (bus.K_size_i == '0) || (bus.N_size_i == '0);
    assign fetch_last   = (k_q == k_size_q - SizeAddrWidth'(1));
    assign last_tile    = (tm_q == tm_last_q) && (tn_q == tn_last_q);

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_accept) state_d = zero_size ? ST_DONE : ST_FETCH;
            ST_FETCH: if (fetch_last)   state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: state_d = last_tile ? ST_DONE : ST_FETCH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_size_q  <= '0;
            k_size_q  <= '0;
            n_size_q  <= '0;
            tm_last_q <= '0;
            tn_last_q <= '0;
            signed_q  <= 1'b0;
            k_q       <= '0;
            tm_q      <= '0;
            tn_q      <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            valid_q <= (state_q == ST_FETCH);
            first_q <= (state_q == ST_FETCH) && (k_q == '0);
            unique case (state_q)
                ST_IDLE: begin
                    if (start_accept) begin
                        m_size_q  <= bus.M_size_i;
                        k_size_q  <= bus.K_size_i;
                        n_size_q  <= bus.N_size_i;
                        signed_q  <= bus.signed_i;
                        tm_last_q <= SizeAddrWidth'(last_tile_index(32'(bus.M_size_i), NumRows));
                        tn_last_q <= SizeAddrWidth'(last_tile_index(32'(bus.N_size_i), NumCols));
                        k_q       <= '0;
                        tm_q      <= '0;
                        tn_q      <= '0;
                    end
                end
                ST_FETCH: k_q <= k_q + SizeAddrWidth'(1);
                ST_WRITE: begin
                    k_q <= '0;
                    if (tn_q == tn_last_q) begin
                        tn_q <= '0;
                        tm_q <= tm_q + SizeAddrWidth'(1);
                    end else begin
                        tn_q <= tn_q + SizeAddrWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------ lane coordinates
    // Global row/column of each lane in the current tile and whether it lies
    // inside the matrix; out-of-range lanes are masked on every port.
    always_comb begin
        for (int r = 0; r < NumRows; r++) begin
            m_idx[r]  = AddrWidth'(tm_q) * AddrWidth'(NumRows) + AddrWidth'(r);
            row_ok[r] = m_idx[r] < AddrWidth'(m_size_q);
        end
        for (int c = 0; c < NumCols; c++) begin
            n_idx[c]  = AddrWidth'(tn_q) * AddrWidth'(NumCols) + AddrWidth'(c);
            col_ok[c] = n_idx[c] < AddrWidth'(n_size_q);
        end
    end

    // -------------------------------------------------- address/write decode
    always_comb begin
        a_addr  = '0;
        b_addr  = '0;
        c_addr  = '0;
        c_wdata = '0;
        c_we    = '0;
        if (state_q == ST_FETCH) begin
            for (int r = 0; r < NumRows; r++) begin
                if (row_ok[r]) a_addr[r] = m_idx[r] * AddrWidth'(k_size_q) + AddrWidth'(k_q);
            end
            for (int c = 0; c < NumCols; c++) begin
                if (col_ok[c]) b_addr[c] = AddrWidth'(k_q) * AddrWidth'(n_size_q) + n_idx[c];
            end
        end
        if (state_q == ST_WRITE) begin
            for (int r = 0; r < NumRows; r++) begin
                for (int c = 0; c < NumCols; c++) begin
                    if (row_ok[r] && col_ok[c]) begin
                        c_we[r*NumCols+c]    = 1'b1;
                        c_addr[r*NumCols+c]  = m_idx[r] * AddrWidth'(n_size_q) + n_idx[c];
                        c_wdata[r*NumCols+c] = acc[r*NumCols+c];
                    end
                end
            end
        end
    end

    assign bus.sram_a_addr_o  = a_addr;
    assign bus.sram_b_addr_o  = b_addr;
    assign bus.sram_c_addr_o  = c_addr;
    assign bus.sram_c_wdata_o = c_wdata;
    assign bus.sram_c_we_o    = c_we;
    assign bus.busy_o         = (state_q == ST_FETCH) || (state_q == ST_DRAIN) || (state_q == ST_WRITE);
    assign bus.done_o         = (state_q == ST_DONE);

    // ------------------------------------------------------------ MAC array
    // Row lane r shares A read port r, column lane c shares B read port c.
    for (genvar r = 0; r < NumRows; r++) begin : g_row
        for (genvar c = 0; c < NumCols; c++) begin : g_col
            gemm_mac_pe #(
                .InDataWidth  (InDataWidth),
                .OutDataWidth (OutDataWidth)
            ) u_pe (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .a         (bus.sram_a_rdata_i[r]),
                .b         (bus.sram_b_rdata_i[c]),
                .is_signed (signed_q),
                .valid     (valid_q),
                .first     (first_q),
                .acc       (acc[r*NumCols+c])
            );
        end
    end

endmodule
